flash_read_cache: RTL and testbench

- Parametrised read-only cache between a CPU-side Avalon-MM slave port and the on-chip flash data port (burst-capable master side).
- Direct-mapped, LINES lines of BURST words each.
- A miss fetches the whole line with one flash burst. Hits return in 1 cycle without touching flash.
- An invalidate input flushes all lines after CSR-driven erase/program, keeping the cache coherent with flash contents.

---
 rtl/flash_read_cache_if.sv | 30 +++
 rtl/flash_read_cache.sv | 161 ++++++++++++++++
 tb/tb_flash_read_cache.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_read_cache_if.sv
// CPU-side Avalon-MM slave and flash-side burst master signals of the read cache.
// The slave modport is the cache's view; master is the CPU/flash environment's view.
`timescale 1ns/1ps
interface flash_read_cache_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32,
    parameter int BC_W   = 4
);
    logic [ADDR_W-1:0] s_addr;
    logic              s_read;
    logic              s_waitrequest;
    logic [DATA_W-1:0] s_readdata;
    logic              s_readdatavalid;
    logic [ADDR_W-1:0] m_addr;
    logic              m_read;
    logic [BC_W-1:0]   m_burstcount;
    logic [DATA_W-1:0] m_readdata;
    logic              m_waitrequest;
    logic              m_readdatavalid;

    modport slave (
        input  s_addr, s_read, m_readdata, m_waitrequest, m_readdatavalid,
        output s_waitrequest, s_readdata, s_readdatavalid, m_addr, m_read, m_burstcount
    );

    modport master (
        output s_addr, s_read, m_readdata, m_waitrequest, m_readdatavalid,
        input  s_waitrequest, s_readdata, s_readdatavalid, m_addr, m_read, m_burstcount
    );
endinterface

// File: rtl/flash_read_cache.sv
// Direct-mapped read-only cache in front of the on-chip flash data port.
// Misses fetch a whole line in one flash burst; hits answer one cycle after acceptance.
`timescale 1ns/1ps
module flash_read_cache #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32,
    parameter int BURST  = 4,
    parameter int LINES  = 8,
    parameter int BC_W   = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    flash_read_cache_if.slave bus,
    input  logic             inv,
    output logic             hit_pulse,
    output logic             miss_pulse
);
    localparam int OFF_W  = $clog2(BURST);
    localparam int IDX_W  = $clog2(LINES);
    localparam int MEM_AW = OFF_W + IDX_W;
    localparam int TAG_W  = ADDR_W - MEM_AW;
    localparam int WORDS  = LINES * BURST;

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t              state_q, state_d;
    logic [MEM_AW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                inv_pend_q, inv_pend_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rdv_q, rdv_d;
    logic                hit_q, hit_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q [LINES];
    logic [TAG_W-1:0]    tag_d [LINES];
    logic [DATA_W-1:0]   data_mem [WORDS];
    logic                rst_sync_q;

    logic [IDX_W-1:0]    s_idx, fill_idx;
    logic [TAG_W-1:0]    s_tag, fill_tag;
    logic [MEM_AW-1:0]   rd_addr, wr_addr;
    logic                hit, wait_c, miss_c, fill_done, mem_we;

    // Reset asserts immediately but releases on a clock edge, so the fabric never sees a runt release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 1'b0;
        else          rst_sync_q <= 1'b1;
    end

    assign s_idx    = IDX_W'(bus.s_addr >> OFF_W);
    assign s_tag    = TAG_W'(bus.s_addr >> MEM_AW);
    assign rd_addr  = bus.s_addr[MEM_AW-1:0];
    assign fill_idx = IDX_W'(base_q >> OFF_W);
    assign fill_tag = TAG_W'(base_q >> MEM_AW);
    // base_q has its offset bits cleared and cnt_q stays below BURST, so OR forms {idx, beat}.
    assign wr_addr  = base_q[MEM_AW-1:0] | cnt_q;
    assign hit      = valid_q[s_idx] && (tag_q[s_idx] == s_tag);

    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_line
            logic fill_this;
            assign fill_this   = fill_done && (fill_idx == IDX_W'(gi));
            // A line filled while an invalidate was pending lands invalid so the held read refetches.
            assign valid_d[gi] = fill_this ? !(inv_pend_q || inv) :
                                 (inv ? 1'b0 : valid_q[gi]);
            assign tag_d[gi]   = fill_this ? fill_tag : tag_q[gi];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        inv_pend_d = inv_pend_q;
        rdata_d    = rdata_q;
        rdv_d      = 1'b0;
        hit_d      = 1'b0;
        wait_c     = 1'b1;
        miss_c     = 1'b0;
        fill_done  = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!inv) begin
                    if (bus.s_read) begin
                        if (hit) begin
                            wait_c  = 1'b0;
                            rdv_d   = 1'b1;
                            hit_d   = 1'b1;
                            rdata_d = data_mem[rd_addr];
                        end else begin
                            miss_c  = 1'b1;
                            base_d  = bus.s_addr & ~ADDR_W'(BURST - 1);
                            state_d = REQ;
                        end
                    end else begin
                        wait_c = 1'b0;
                    end
                end
            end
            REQ: begin
                if (inv) inv_pend_d = 1'b1;
                if (!bus.m_waitrequest) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            FILL: begin
                if (inv) inv_pend_d = 1'b1;
                if (bus.m_readdatavalid) begin
                    mem_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == MEM_AW'(BURST - 1)) begin
                        fill_done  = 1'b1;
                        inv_pend_d = 1'b0;
                        cnt_d      = '0;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            base_q     <= '0;
            inv_pend_q <= 1'b0;
            rdata_q    <= '0;
            rdv_q      <= 1'b0;
            hit_q      <= 1'b0;
            valid_q    <= '0;
            for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            inv_pend_q <= inv_pend_d;
            rdata_q    <= rdata_d;
            rdv_q      <= rdv_d;
            hit_q      <= hit_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) data_mem[wr_addr] <= bus.m_readdata;
    end

    assign bus.s_waitrequest   = wait_c || !rst_sync_q;
    assign bus.s_readdata      = rdata_q;
    assign bus.s_readdatavalid = rdv_q;
    assign bus.m_read          = (state_q == REQ);
    assign bus.m_addr          = base_q;
    assign bus.m_burstcount    = BC_W'(BURST);
    assign hit_pulse           = hit_q;
    assign miss_pulse          = miss_c && rst_sync_q;
endmodule

// File: tb/tb_flash_read_cache.sv
// Self-checking bench for flash_read_cache: a CPU driver pushes expected read data and
// expected flash bursts into queues; a read monitor and a flash model pop and compare.
`timescale 1ns/1ps
module tb_flash_read_cache;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;
    localparam int BURST  = 4;
    localparam int LINES  = 8;
    localparam int BC_W   = 4;
    localparam int BUDGET = 300;

    typedef struct { logic [31:0] data; int cyc; } exp_t;
    typedef struct { logic [16:0] addr; int stall; int inv_beat; } burst_t;

    logic clk;
    logic rst_n;
    logic inv_main, inv_flash, inv_w;
    logic hit_pulse, miss_pulse;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc_cnt = 0;
    int   misses_seen = 0;
    int   rdv_seen = 0;
    int   beat_idx = -1;
    exp_t   exp_q[$];
    burst_t burst_q[$];

    flash_read_cache_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BC_W(BC_W)) bus ();

    flash_read_cache #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST(BURST), .LINES(LINES), .BC_W(BC_W)
    ) dut (
        .clock(clk), .reset_n(rst_n), .bus(bus),
        .inv(inv_w), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
    );

    assign inv_w = inv_main | inv_flash;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [31:0] flash_word(input logic [16:0] a);
        return 32'hC0DE_0000 ^ ({15'd0, a} * 32'h0000_9E37);
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_burst(input logic [16:0] a, input int stall, input int inv_beat);
        burst_t b;
        b.addr = a; b.stall = stall; b.inv_beat = inv_beat;
        burst_q.push_back(b);
    endtask

    task automatic check_reset_outs(input string tag);
        check_value({tag, "_wait"},  32'(bus.s_waitrequest), 32'd1);
        check_value({tag, "_rdv"},   32'(bus.s_readdatavalid), 32'd0);
        check_value({tag, "_rdata"}, bus.s_readdata, 32'd0);
        check_value({tag, "_mread"}, 32'(bus.m_read), 32'd0);
        check_value({tag, "_maddr"}, 32'(bus.m_addr), 32'd0);
        check_value({tag, "_bc"},    32'(bus.m_burstcount), 32'(BURST));
        check_value({tag, "_hit"},   32'(hit_pulse), 32'd0);
        check_value({tag, "_miss"},  32'(miss_pulse), 32'd0);
    endtask

    // Holds s_read until accepted, then queues the word the monitor must see next cycle.
    task automatic do_read(input logic [16:0] a, input bit exp_miss);
        exp_t e;
        int   n;
        bus.s_addr = a;
        bus.s_read = 1'b1;
        @(negedge clk);
        check_value("first_miss_pulse", 32'(miss_pulse), 32'(exp_miss));
        if (!exp_miss) check_value("hit_wait", 32'(bus.s_waitrequest), 32'd0);
        n = 0;
        while (bus.s_waitrequest && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) begin
            check_value("accept_timeout", 32'(n), 32'd0);
            bus.s_read = 1'b0;
        end else begin
            e.data = flash_word(a);
            e.cyc  = cyc_cnt;
            @(posedge clk);
            exp_q.push_back(e);
            #1;
            bus.s_read = 1'b0;
            $display("read addr=0x%05h miss=%0d accepted", a, exp_miss);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (miss_pulse === 1'b1) misses_seen++;
        if (bus.s_readdatavalid === 1'b1) begin
            rdv_seen++;
            if (exp_q.size() == 0) begin
                check_value("unexpected_rdv", bus.s_readdata, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_value("rdata", bus.s_readdata, e.data);
                check_value("rd_latency", 32'(cyc_cnt), 32'(e.cyc + 1));
                check_value("hit_pulse", 32'(hit_pulse), 32'd1);
            end
        end
    end

    // Flash slave: optional request stall, 1 cycle of latency, then BURST back-to-back beats.
    initial begin : flash_model
        burst_t      b;
        logic [16:0] a;
        bus.m_waitrequest   = 1'b0;
        bus.m_readdatavalid = 1'b0;
        bus.m_readdata      = '0;
        inv_flash           = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.m_read === 1'b1) begin
                a = bus.m_addr;
                b.addr = a; b.stall = 0; b.inv_beat = -1;
                if (burst_q.size() == 0) check_value("unexpected_burst", 32'(a), 32'h1FFFF);
                else begin
                    b = burst_q.pop_front();
                    check_value("burst_addr", 32'(a), 32'(b.addr));
                end
                check_value("burstcount", 32'(bus.m_burstcount), 32'(BURST));
                if (b.stall > 0) begin
                    bus.m_waitrequest = 1'b1;
                    for (int i = 0; i < b.stall; i++) begin
                        @(negedge clk);
                        check_value("stall_mread", 32'(bus.m_read), 32'd1);
                        check_value("stall_maddr", 32'(bus.m_addr), 32'(a));
                        check_value("stall_bc", 32'(bus.m_burstcount), 32'(BURST));
                        check_value("stall_swait", 32'(bus.s_waitrequest), 32'd1);
                    end
                    bus.m_waitrequest = 1'b0;
                end
                @(posedge clk); #1;
                check_value("mread_drop", 32'(bus.m_read), 32'd0);
                $display("burst addr=0x%05h stall=%0d inv_beat=%0d", a, b.stall, b.inv_beat);
                @(posedge clk); #1;
                for (int k = 0; k < BURST; k++) begin
                    while (rst_n !== 1'b1) begin
                        @(posedge clk); #1;
                    end
                    bus.m_readdatavalid = 1'b1;
                    bus.m_readdata      = flash_word(17'(a + 17'(k)));
                    beat_idx            = k;
                    inv_flash           = (k == b.inv_beat);
                    @(posedge clk); #1;
                    bus.m_readdatavalid = 1'b0;
                    inv_flash           = 1'b0;
                end
                beat_idx = -1;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        rst_n      = 1'b0;
        inv_main   = 1'b0;
        bus.s_read = 1'b0;
        bus.s_addr = '0;
        repeat (3) @(negedge clk);
        check_reset_outs("por");
        rst_n = 1'b1;
        @(negedge clk);
        check_value("wait_after_release", 32'(bus.s_waitrequest), 32'd0);
        @(posedge clk); #1;

        // Cold miss, then hits on the same line back-to-back.
        push_burst(17'h00004, 0, -1);
        do_read(17'h00005, 1'b1);
        do_read(17'h00004, 1'b0);
        do_read(17'h00006, 1'b0);
        do_read(17'h00007, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_value("rdv_one_pulse", 32'(bus.s_readdatavalid), 32'd0);
        check_value("rdata_hold", bus.s_readdata, flash_word(17'h00007));
        @(posedge clk); #1;

        // Conflict on IDX 1 evicts, then the original line refetches.
        push_burst(17'h00024, 0, -1);
        do_read(17'h00024, 1'b1);
        push_burst(17'h00004, 0, -1);
        do_read(17'h00005, 1'b1);

        // Flash holds waitrequest for 5 cycles.
        push_burst(17'h00040, 5, -1);
        do_read(17'h00040, 1'b1);

        // inv in IDLE beats a would-be hit, then a mid-fill inv forces a second burst.
        bus.s_addr = 17'h00004;
        bus.s_read = 1'b1;
        inv_main   = 1'b1;
        @(negedge clk);
        check_value("inv_wait", 32'(bus.s_waitrequest), 32'd1);
        check_value("inv_no_miss", 32'(miss_pulse), 32'd0);
        @(posedge clk); #1;
        inv_main = 1'b0;
        push_burst(17'h00004, 0, 2);
        push_burst(17'h00004, 0, -1);
        do_read(17'h00004, 1'b1);
        do_read(17'h00006, 1'b0);

        // Reset during beat 1; the remaining beats arrive after release and must be ignored.
        push_burst(17'h00060, 0, -1);
        bus.s_addr = 17'h00060;
        bus.s_read = 1'b1;
        n = 0;
        while (!(beat_idx == 1 && bus.m_readdatavalid === 1'b1) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check_value("beat1_timeout", 32'(n < BUDGET), 32'd1);
        rst_n      = 1'b0;
        bus.s_read = 1'b0;
        #1;
        check_reset_outs("midfill");
        repeat (2) @(negedge clk);
        check_reset_outs("midfill_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_value("wait_after_rel2", 32'(bus.s_waitrequest), 32'd0);
        check_value("mread_after_rel", 32'(bus.m_read), 32'd0);
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        push_burst(17'h00004, 0, -1);
        do_read(17'h00004, 1'b1);
        push_burst(17'h00060, 0, -1);
        do_read(17'h00060, 1'b1);
        do_read(17'h00061, 1'b0);
        repeat (3) @(negedge clk);

        check_value("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check_value("burst_q_empty", 32'(burst_q.size()), 32'd0);
        check_value("miss_count", 32'(misses_seen), 32'd9);
        check_value("rdv_count", 32'(rdv_seen), 32'd12);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
